// File: rtl/jtframe_sega_pkg.sv
// Shared types and constants for the Sega DB9 gamepad reader.
package jtframe_sega_pkg;

    // Sequencer states: one idle period followed by eight select phases
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PH0, ST_PH1, ST_PH2, ST_PH3,
        ST_PH4, ST_PH5, ST_PH6, ST_PH7
    } state_t;

    // Bit positions in the 12-bit active-high button word
    localparam int BTN_R     = 0;
    localparam int BTN_L     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_U     = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_X     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_Z     = 10;
    localparam int BTN_MODE  = 11;

    localparam int          JOY_W     = 12;
    localparam int          PIN_W     = 6;
    localparam int          NUM_PADS  = 2;
    // Buttons that every pad type reports; X/Y/Z/Mode only exist on 6-button pads
    localparam logic [11:0] BASE_MASK = 12'h0FF;
    localparam logic        IDLE_SEL  = 1'b1;

    typedef struct packed {
        logic [JOY_W-1:0] joy;
        logic             six;
        logic             present;
    } pad_res_t;

    function automatic state_t next_state(input state_t s);
        case (s)
            ST_IDLE: return ST_PH0;
            ST_PH0:  return ST_PH1;
            ST_PH1:  return ST_PH2;
            ST_PH2:  return ST_PH3;
            ST_PH3:  return ST_PH4;
            ST_PH4:  return ST_PH5;
            ST_PH5:  return ST_PH6;
            ST_PH6:  return ST_PH7;
            default: return ST_IDLE;
        endcase
    endfunction

    // Select is high while idle and in even phases, low in odd phases
    function automatic logic sel_of(input state_t s);
        case (s)
            ST_PH1, ST_PH3, ST_PH5, ST_PH7: return 1'b0;
            default:                        return IDLE_SEL;
        endcase
    endfunction

endpackage

// File: rtl/jtframe_sega_dec.sv
// Per-pad decoder: input synchronizer, phase scratch registers and commit.
module jtframe_sega_dec
    import jtframe_sega_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIN_W-1:0] pin,
    input  state_t           state,
    input  logic             sample,
    input  logic             commit,
    output pad_res_t         res
);

    logic [PIN_W-1:0] s1, s2, p;
    logic [JOY_W-1:0] word;
    logic             det3, det6;

    // Two-flop synchronizer; idle lines read high through the pull-ups
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= pin;
            s2 <= s1;
        end
    end

    assign p = ~s2;

    // Capture each phase's lines on the last cycle of that phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            det3 <= 1'b0;
            det6 <= 1'b0;
        end else if (sample) begin
            case (state)
                ST_PH0: begin
                    word[BTN_U] <= p[0];
                    word[BTN_D] <= p[1];
                    word[BTN_L] <= p[2];
                    word[BTN_R] <= p[3];
                    word[BTN_B] <= p[4];
                    word[BTN_C] <= p[5];
                end
                ST_PH1: begin
                    word[BTN_A]     <= p[4];
                    word[BTN_START] <= p[5];
                    // L and R both low with select low only happens with a pad attached
                    det3            <= p[3] & p[2];
                end
                ST_PH5: det6 <= &p[3:0];
                ST_PH6: begin
                    if (det6) begin
                        word[BTN_Z]    <= p[0];
                        word[BTN_Y]    <= p[1];
                        word[BTN_X]    <= p[2];
                        word[BTN_MODE] <= p[3];
                    end
                end
                default: ;
            endcase
        end
    end

    // Publish the whole scan at once; absent pads never leak stale scratch data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= '0;
        end else if (commit) begin
            res.present <= det3;
            res.six     <= det3 & det6;
            res.joy     <= !det3 ? '0 : (det6 ? word : (word & BASE_MASK));
        end
    end

endmodule

// File: rtl/jtframe_sega_joyrd.sv
// Two-pad Sega DB9 reader: shared select sequencer plus one decoder per pad.
module jtframe_sega_joyrd
    import jtframe_sega_pkg::*;
#(
    parameter int PHASE_CYC = 480,
    parameter int IDLE_CYC  = 96000,
    parameter int CW        = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PIN_W-1:0]  joy1_pin,
    input  logic [PIN_W-1:0]  joy2_pin,
    output logic              joy_select,
    output logic [JOY_W-1:0]  joy1,
    output logic [JOY_W-1:0]  joy2,
    output logic              six1,
    output logic              six2,
    output logic              present1,
    output logic              present2,
    output logic              scan_done
);

    state_t                         state;
    logic [CW-1:0]                  cnt;
    logic                           last, sample, commit;
    logic [NUM_PADS-1:0][PIN_W-1:0] pins;
    pad_res_t [NUM_PADS-1:0]        res;

    assign sample = (state != ST_IDLE) && (cnt == CW'(PHASE_CYC-1));
    assign last   = (state == ST_IDLE) ? (cnt == CW'(IDLE_CYC-1)) : sample;
    assign commit = (state == ST_PH7) && sample;

    // Phase sequencer; select is registered alongside the state it belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            joy_select <= IDLE_SEL;
            scan_done  <= 1'b0;
        end else begin
            scan_done <= commit;
            if (last) begin
                cnt        <= '0;
                state      <= next_state(state);
                joy_select <= sel_of(next_state(state));
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign pins[0] = joy1_pin;
    assign pins[1] = joy2_pin;

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
        jtframe_sega_dec u_dec (
            .clk    (clk),
            .rst_n  (rst_n),
            .pin    (pins[g]),
            .state  (state),
            .sample (sample),
            .commit (commit),
            .res    (res[g])
        );
    end

    assign joy1     = res[0].joy;
    assign six1     = res[0].six;
    assign present1 = res[0].present;
    assign joy2     = res[1].joy;
    assign six2     = res[1].six;
    assign present2 = res[1].present;

endmodule

// File: tb/tb_jtframe_sega_joyrd.sv
// Bench for the Sega pad reader: behavioural 3/6-button pad models and a
// scoreboard of expected scan results checked on each scan_done.
module tb_jtframe_sega_joyrd;

    localparam int PHASE_CYC = 8;
    localparam int IDLE_CYC  = 64;
    localparam int SCAN      = 8*PHASE_CYC + IDLE_CYC;

    typedef struct {
        logic [11:0] j1, j2;
        logic        s1, s2, p1, p2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  joy1_pin, joy2_pin;
    logic        joy_select, six1, six2, present1, present2, scan_done;
    logic [11:0] joy1, joy2;

    // pad configuration driven by the tests
    logic        p1_pres = 1'b0, p1_six = 1'b0, p1_ph6 = 1'b0;
    logic        p2_pres = 1'b0, p2_six = 1'b0, p2_ph6 = 1'b0;
    logic [11:0] p1_btn = '0, p2_btn = '0;

    int   n_tests = 0, n_fail = 0;
    exp_t q[$];

    jtframe_sega_joyrd #(.PHASE_CYC(PHASE_CYC), .IDLE_CYC(IDLE_CYC), .CW(17)) dut (
        .clk(clk), .rst_n(rst_n), .joy1_pin(joy1_pin), .joy2_pin(joy2_pin),
        .joy_select(joy_select), .joy1(joy1), .joy2(joy2), .six1(six1), .six2(six2),
        .present1(present1), .present2(present2), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    // pad-side model of the select low-pulse counter with its idle timeout
    int   lows = 0, hi_cnt = 0;
    logic prev_sel = 1'b1;
    always @(posedge clk) begin
        prev_sel <= joy_select;
        hi_cnt   <= joy_select ? hi_cnt + 1 : 0;
        if (prev_sel && !joy_select) lows <= (hi_cnt > 20) ? 1 : lows + 1;
    end

    function automatic logic [5:0] pad_pins(input logic pres, six, ph6, sel,
                                            input int lw, input logic [11:0] b);
        logic [5:0] p;
        if (!pres) return 6'h3F;
        if (sel) begin
            p = {b[6], b[5], b[0], b[1], b[2], b[3]};
            if (lw == 3 && six)      p[3:0] = {b[11], b[8], b[9], b[10]};
            else if (lw == 3 && ph6) p[3:0] = 4'hF;
        end else begin
            p = {b[7], b[4], 2'b11, b[2], b[3]};
            if (lw == 3 && six) p[3:0] = 4'hF;
        end
        return ~p;
    endfunction

    always_comb joy1_pin = pad_pins(p1_pres, p1_six, p1_ph6, joy_select, lows, p1_btn);
    always_comb joy2_pin = pad_pins(p2_pres, p2_six, p2_ph6, joy_select, lows, p2_btn);

    function automatic logic [11:0] exp_joy(input logic pres, six, input logic [11:0] b);
        if (!pres) return 12'h000;
        return six ? b : (b & 12'h0FF);
    endfunction

    task automatic push_exp();
        exp_t e;
        e.j1 = exp_joy(p1_pres, p1_six, p1_btn);
        e.j2 = exp_joy(p2_pres, p2_six, p2_btn);
        e.s1 = p1_pres & p1_six;
        e.s2 = p2_pres & p2_six;
        e.p1 = p1_pres;
        e.p2 = p2_pres;
        q.push_back(e);
    endtask

    // wait for the next scan_done (bounded); outputs must hold until then
    task automatic wait_scan(output int n);
        logic [11:0] j1 = joy1, j2 = joy2;
        logic [3:0]  f = {six1, six2, present1, present2};
        int          moved = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!scan_done && (joy1 !== j1 || joy2 !== j2 ||
                               {six1, six2, present1, present2} !== f)) moved++;
        end while (!scan_done && n < 4*SCAN);
        n_tests++;
        if (!scan_done) begin
            n_fail++;
            $display("FAIL scan_timeout: no scan_done within %0d cycles", n);
        end
        n_tests++;
        if (moved !== 0) begin
            n_fail++;
            $display("FAIL hold_stable: outputs changed %0d times between commits, required 0", moved);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = q.pop_front();
        n_tests += 6;
        if (joy1 !== e.j1)     begin n_fail++; $display("FAIL %s joy1: got %h want %h", tag, joy1, e.j1); end
        if (joy2 !== e.j2)     begin n_fail++; $display("FAIL %s joy2: got %h want %h", tag, joy2, e.j2); end
        if (six1 !== e.s1)     begin n_fail++; $display("FAIL %s six1: got %b want %b", tag, six1, e.s1); end
        if (six2 !== e.s2)     begin n_fail++; $display("FAIL %s six2: got %b want %b", tag, six2, e.s2); end
        if (present1 !== e.p1) begin n_fail++; $display("FAIL %s present1: got %b want %b", tag, present1, e.p1); end
        if (present2 !== e.p2) begin n_fail++; $display("FAIL %s present2: got %b want %b", tag, present2, e.p2); end
    endtask

    task automatic scan_and_check(input string tag);
        int n;
        push_exp();
        wait_scan(n);
        check_out(tag);
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({joy_select, scan_done, six1, six2, present1, present2} !== 6'b100000 ||
            joy1 !== 12'h0 || joy2 !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_state: sel=%b done=%b joy1=%h joy2=%h, required sel=1 rest 0",
                     joy_select, scan_done, joy1, joy2);
        end
        rst_n = 1'b1;
        push_exp();
        wait_scan(n);
        n_tests++;
        if (n !== SCAN) begin
            n_fail++;
            $display("FAIL first_scan_latency: got %0d cycles want %0d", n, SCAN);
        end
        check_out("no_pads");
    endtask

    task automatic test_select_wave();
        int   bad = 0, dbad = 0;
        logic want;
        push_exp();
        for (int i = 0; i < SCAN; i++) begin
            if (i > 0) @(negedge clk);
            want = (i < IDLE_CYC) ? 1'b1 : ~(((i - IDLE_CYC) / PHASE_CYC) % 2 == 1);
            if (joy_select !== want) bad++;
            if (scan_done !== (i == 0)) dbad++;
        end
        @(negedge clk);
        n_tests += 3;
        if (bad !== 0)  begin n_fail++; $display("FAIL select_wave: %0d wrong cycles, required 0", bad); end
        if (dbad !== 0) begin n_fail++; $display("FAIL done_width: %0d wrong cycles, required 0", dbad); end
        if (scan_done !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_period: scan_done=%b at cycle %0d, required 1", scan_done, SCAN);
        end
        check_out("select_wave");
    endtask

    task automatic test_three_button();
        p1_pres = 1'b1; p1_six = 1'b0; p1_btn = 12'h098;
        scan_and_check("three_button");
        n_tests++;
        if (joy1 !== 12'h098) begin n_fail++; $display("FAIL three_button_word: got %h want 098", joy1); end
    endtask

    task automatic test_six_button();
        p2_pres = 1'b1; p2_six = 1'b1; p2_btn = 12'h901;
        scan_and_check("six_button");
        n_tests++;
        if (joy2 !== 12'h901) begin n_fail++; $display("FAIL six_button_word: got %h want 901", joy2); end
    endtask

    task automatic test_reset_mid_scan();
        int n;
        repeat (IDLE_CYC + 3*PHASE_CYC + 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (joy1 !== 12'h0 || joy2 !== 12'h0 || joy_select !== 1'b1 ||
            {six1, six2, present1, present2, scan_done} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: joy1=%h joy2=%h sel=%b, required 000 000 1",
                     joy1, joy2, joy_select);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_exp();
        wait_scan(n);
        n_tests++;
        if (n !== SCAN) begin
            n_fail++;
            $display("FAIL mid_reset_latency: got %0d cycles want %0d", n, SCAN);
        end
        check_out("after_mid_reset");
    endtask

    task automatic test_removal();
        p1_pres = 1'b0;
        scan_and_check("pad1_removed");
    endtask

    task automatic test_fake_six();
        p2_six = 1'b0; p2_ph6 = 1'b1; p2_btn = 12'hF01;
        scan_and_check("det6_false");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            p1_pres = 1'($urandom); p1_six = 1'($urandom); p1_ph6 = 1'($urandom);
            p2_pres = 1'($urandom); p2_six = 1'($urandom); p2_ph6 = 1'($urandom);
            p1_btn  = 12'($urandom); p2_btn = 12'($urandom);
            scan_and_check("back_to_back");
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_select_wave();
        test_three_button();
        test_six_button();
        test_reset_mid_scan();
        test_removal();
        test_fake_six();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtframe_sega_joyrd.md
Name: jtframe_sega_joyrd

Overview:
- Reads two Sega-style (DB9, 3- or 6-button) gamepads on the DeMiSTify target.
- The pads share one select line, JOY_SELECT, and each returns 6 active-low data lines, JOY1/JOY2.
- The block drives the select sequence, detects pad type and decodes the buttons.
- It delivers active-high 12-bit button words to the MiST frame joystick logic, which sits directly downstream on joy1_bus/joy2_bus.

Parameters:
- PHASE_CYC, 480, clk cycles per select phase (10 us at 48 MHz); must be >= 4.
- IDLE_CYC, 96000, clk cycles with select high after phase 7 (2 ms), so the pad's 6-button counter times out.
- CW, 17, counter width; must hold max(PHASE_CYC, IDLE_CYC)-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- joy1_pin  in  6  pad 1 lines, active-low, asynchronous
- joy2_pin  in  6  pad 2 lines, active-low, asynchronous
- joy_select  out  1  shared pad select line
- joy1  out  12  pad 1 buttons, active-high: [0]R [1]L [2]D [3]U [4]A [5]B [6]C [7]Start [8]X [9]Y [10]Z [11]Mode
- joy2  out  12  pad 2 buttons, same layout
- six1  out  1  pad 1 identified as 6-button in the last scan
- six2  out  1  pad 2 identified as 6-button in the last scan
- present1  out  1  pad 1 detected in the last scan
- present2  out  1  pad 2 detected in the last scan
- scan_done  out  1  one-cycle strobe when all outputs update

Behaviour:
- Input sync:
  - Each 6-bit bus passes through a 2-FF synchronizer.
  - Synchronizer reset value is 6'h3F (pull-ups idle).
  - All decode uses synchronized, inverted data (p = ~sync).
- Reset:
  - joy_select=1; joy1, joy2, six*, present* = 0; scan_done=0.
  - FSM starts in IDLE with the counter cleared.
  - Reset asserted mid-scan aborts the scan; the next scan starts from IDLE after a full IDLE_CYC.
- FSM states: IDLE, PH0 through PH7.
  - joy_select is 1 in IDLE and in even phases, 0 in odd phases.
  - joy_select is registered and changes on the cycle the state changes.
- Timing:
  - Each PHn lasts exactly PHASE_CYC cycles.
  - Sampling happens on the last cycle of the phase (counter == PHASE_CYC-1), so the pad has settled.
  - IDLE lasts IDLE_CYC cycles, then PH0 starts.
  - Scan period = 8*PHASE_CYC + IDLE_CYC.
- Sampling, bits of p per pad, in scratch registers:
  - PH0 (sel=1): U=p[0], D=p[1], L=p[2], R=p[3], B=p[4], C=p[5].
  - PH1 (sel=0): A=p[4], Start=p[5]; det3 = p[3]&p[2] (L and R both reading low means a pad is present).
  - PH5 (sel=0): det6 = &p[3:0].
  - PH6 (sel=1): Z=p[0], Y=p[1], X=p[2], Mode=p[3]; captured only when det6.
  - PH2, PH3, PH4 and PH7 only toggle select; no sampling.
- Commit, on the cycle leaving PH7 into IDLE:
  - present = det3.
  - six = det3 & det6.
  - joyN = present ? assembled word : 0.
  - X/Y/Z/Mode are forced to 0 when six=0.
  - scan_done pulses for that single cycle; both pads commit in the same cycle.
- Outputs hold stable between commits; scratch registers are never visible.
- Pad hot-plug or removal mid-scan: the scan still completes. A missing pad gives present=0 and a zero word, never stale data.
- The two pads are independent; mixed 3/6-button configurations are valid.

Decomposition:
- Shared package jtframe_sega_pkg holds:
  - the state enum (IDLE, PH0..PH7);
  - bit-index constants for the 12-bit button word;
  - localparam IDLE_SEL = 1'b1.
- Sub-module jtframe_sega_dec is instantiated twice (once per pad). It contains the synchronizer, scratch registers and commit logic, and takes state, sample strobe and commit strobe from the shared sequencer in the top.

Test Plan:
- Reset, no pads (pins 6'h3F) -> joy_select=1 during IDLE; after the first scan, scan_done pulses once; present1=present2=0, joy1=joy2=0.
- 3-button model on pad 1, Up+A+Start pressed -> present1=1, six1=0, joy1=12'h098; pad 2 absent gives joy2=0.
- 6-button model on pad 2, X+Mode+Right pressed -> six2=1, joy2=12'h901.
- joy_select waveform with PHASE_CYC=8, IDLE_CYC=64 -> pattern 1,0,1,0,1,0,1,0 of 8 cycles each, then 1 for 64 cycles; scan_done every 128 cycles.
- Assert rst_n during PH3 with buttons held -> outputs go to 0 asynchronously, joy_select=1; first scan_done arrives 64+64 cycles after release (IDLE_CYC + 8*PHASE_CYC with the values above).
- Remove pad 1 between scans, then on a 6-button pad force det6 false (3-button model) -> present1=0, joy1=0; X/Y/Z/Mode stay 0 even if PH6 pins read low.
